// File: rtl/pong_game_ctrl_if.sv
// Control/status bundle between the pong game sequencer and the rest of the video datapath.
// master: VGA timing, buttons and ball engine side; slave: the game controller.
interface pong_game_ctrl_if #(
    parameter int SCORE_W = 4
);
    logic               vsync;
    logic               start_btn;
    logic               pause_btn;
    logic               miss_left;
    logic               miss_right;
    logic               ball_run;
    logic               ball_load;
    logic               serve_dir;
    logic [SCORE_W-1:0] score_left;
    logic [SCORE_W-1:0] score_right;
    logic               game_over;
    logic               winner;
    logic [2:0]         state;

    modport master (
        output vsync, start_btn, pause_btn, miss_left, miss_right,
        input  ball_run, ball_load, serve_dir, score_left, score_right,
               game_over, winner, state
    );

    modport slave (
        input  vsync, start_btn, pause_btn, miss_left, miss_right,
        output ball_run, ball_load, serve_dir, score_left, score_right,
               game_over, winner, state
    );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game-flow sequencer: serve/play/point/pause/over, scores, ball engine gating.
// Latency: 1 clk from input event to registered outputs; no backpressure, pulses are consumed as they arrive.
module pong_game_ctrl #(
    parameter int SERVE_DELAY_FRAMES = 60,
    parameter int POINT_HOLD_FRAMES  = 30,
    parameter int WIN_SCORE          = 7,
    parameter int SCORE_W            = 4,
    parameter int FRAME_CNT_W        = 8
) (
    input  logic              clk,
    input  logic              reset,
    pong_game_ctrl_if.slave   bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SERVE = 3'd1,
        PLAY  = 3'd2,
        POINT = 3'd3,
        PAUSE = 3'd4,
        OVER  = 3'd5
    } state_e;

    localparam logic [FRAME_CNT_W-1:0] SERVE_LAST = FRAME_CNT_W'(SERVE_DELAY_FRAMES - 1);
    localparam logic [FRAME_CNT_W-1:0] POINT_LAST = FRAME_CNT_W'(POINT_HOLD_FRAMES - 1);
    localparam logic [SCORE_W-1:0]     WIN_VAL    = SCORE_W'(WIN_SCORE);

    state_e                 state_q, state_d;
    logic [SCORE_W-1:0]     score_left_q, score_left_d;
    logic [SCORE_W-1:0]     score_right_q, score_right_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic                   serve_dir_q, serve_dir_d;
    logic                   winner_q, winner_d;
    logic                   run_q, run_d;
    logic                   load_q, load_d;
    logic                   game_over_q, game_over_d;
    logic                   vsync_q, start_q, pause_q;

    logic frame_tick, start_rise, pause_rise;

    assign frame_tick = vsync_q & ~bus.vsync;
    assign start_rise = ~start_q & bus.start_btn;
    assign pause_rise = ~pause_q & bus.pause_btn;

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_comb begin
        state_d       = state_q;
        score_left_d  = score_left_q;
        score_right_d = score_right_q;
        frame_cnt_d   = frame_cnt_q;
        serve_dir_d   = serve_dir_q;
        winner_d      = winner_q;

        case (state_q)
            IDLE: begin
                if (start_rise) begin
                    state_d     = SERVE;
                    frame_cnt_d = '0;
                end
            end
            SERVE: begin
                if (frame_tick) begin
                    if (frame_cnt_q == SERVE_LAST) begin
                        state_d     = PLAY;
                        frame_cnt_d = '0;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
            end
            PLAY: begin
                // A simultaneous miss on both sides is a let: re-serve, nobody scores.
                if (bus.miss_left && bus.miss_right) begin
                    state_d     = SERVE;
                    frame_cnt_d = '0;
                end else if (bus.miss_left) begin
                    score_right_d = sat_inc(score_right_q);
                    serve_dir_d   = 1'b0;
                    state_d       = POINT;
                end else if (bus.miss_right) begin
                    score_left_d = sat_inc(score_left_q);
                    serve_dir_d  = 1'b1;
                    state_d      = POINT;
                end else if (pause_rise) begin
                    state_d = PAUSE;
                end
            end
            POINT: begin
                if (frame_tick) begin
                    if (frame_cnt_q == POINT_LAST) begin
                        frame_cnt_d = '0;
                        if (score_left_q == WIN_VAL) begin
                            state_d  = OVER;
                            winner_d = 1'b0;
                        end else if (score_right_q == WIN_VAL) begin
                            state_d  = OVER;
                            winner_d = 1'b1;
                        end else begin
                            state_d = SERVE;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + 1'b1;
                    end
                end
            end
            PAUSE: begin
                if (pause_rise) state_d = PLAY;
            end
            OVER: begin
                if (start_rise) begin
                    score_left_d  = '0;
                    score_right_d = '0;
                    serve_dir_d   = 1'b1;
                    frame_cnt_d   = '0;
                    state_d       = SERVE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they register alongside it.
        run_d       = (state_d == PLAY);
        load_d      = (state_d == IDLE) || (state_d == SERVE) || (state_d == OVER);
        game_over_d = (state_d == OVER);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            score_left_q  <= '0;
            score_right_q <= '0;
            frame_cnt_q   <= '0;
            serve_dir_q   <= 1'b1;
            winner_q      <= 1'b0;
            run_q         <= 1'b0;
            load_q        <= 1'b1;
            game_over_q   <= 1'b0;
            vsync_q       <= 1'b1;
            start_q       <= 1'b1;
            pause_q       <= 1'b1;
        end else begin
            state_q       <= state_d;
            score_left_q  <= score_left_d;
            score_right_q <= score_right_d;
            frame_cnt_q   <= frame_cnt_d;
            serve_dir_q   <= serve_dir_d;
            winner_q      <= winner_d;
            run_q         <= run_d;
            load_q        <= load_d;
            game_over_q   <= game_over_d;
            vsync_q       <= bus.vsync;
            start_q       <= bus.start_btn;
            pause_q       <= bus.pause_btn;
        end
    end

    assign bus.state       = state_q;
    assign bus.score_left  = score_left_q;
    assign bus.score_right = score_right_q;
    assign bus.serve_dir   = serve_dir_q;
    assign bus.winner      = winner_q;
    assign bus.ball_run    = run_q;
    assign bus.ball_load   = load_q;
    assign bus.game_over   = game_over_q;
endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl with SERVE_DELAY=3, POINT_HOLD=2, WIN_SCORE=2.
module tb_pong_game_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    pong_game_ctrl_if #(.SCORE_W(4)) bus ();

    pong_game_ctrl #(
        .SERVE_DELAY_FRAMES(3),
        .POINT_HOLD_FRAMES (2),
        .WIN_SCORE         (2),
        .SCORE_W           (4),
        .FRAME_CNT_W       (8)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic frame_pulse();
        bus.vsync = 1'b0;
        tick();
        bus.vsync = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start_btn = 1'b1;
        tick();
        tick();
        n_checks++; if (bus.state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", bus.state); end
        n_checks++; if ({bus.ball_run, bus.ball_load, bus.serve_dir, bus.game_over, bus.winner} !== 5'b01100) begin
            n_fail++; $display("FAIL reset_flags: run/load/dir/over/win got %b want 01100",
                {bus.ball_run, bus.ball_load, bus.serve_dir, bus.game_over, bus.winner}); end
        n_checks++; if ({bus.score_left, bus.score_right} !== 8'h00) begin n_fail++; $display("FAIL reset_scores: got %h want 00", {bus.score_left, bus.score_right}); end
        reset = 1'b0;
        tick();
        tick();
        n_checks++; if (bus.state !== 3'd0) begin n_fail++; $display("FAIL held_start: got %0d want 0", bus.state); end
        bus.start_btn = 1'b0;
        tick();
        bus.start_btn = 1'b1;
        tick();
        n_checks++; if (bus.state !== 3'd1) begin n_fail++; $display("FAIL start_serve: got %0d want 1", bus.state); end
        n_checks++; if (bus.ball_load !== 1'b1 || bus.ball_run !== 1'b0) begin n_fail++; $display("FAIL serve_load: load=%b run=%b want 1/0", bus.ball_load, bus.ball_run); end
        bus.start_btn = 1'b0;
        tick();
    endtask

    task automatic test_serve_delay();
        frame_pulse();
        frame_pulse();
        n_checks++; if (bus.state !== 3'd1) begin n_fail++; $display("FAIL serve_early: got %0d want 1", bus.state); end
        bus.vsync = 1'b0;
        tick();
        n_checks++; if (bus.state !== 3'd2) begin n_fail++; $display("FAIL serve_to_play: got %0d want 2", bus.state); end
        n_checks++; if (bus.ball_run !== 1'b1 || bus.ball_load !== 1'b0) begin n_fail++; $display("FAIL play_flags: run=%b load=%b want 1/0", bus.ball_run, bus.ball_load); end
        bus.vsync = 1'b1;
        tick();
    endtask

    task automatic test_point();
        bus.miss_left = 1'b1;
        tick();
        bus.miss_left = 1'b0;
        n_checks++; if (bus.state !== 3'd3) begin n_fail++; $display("FAIL point_state: got %0d want 3", bus.state); end
        n_checks++; if (bus.score_right !== 4'd1 || bus.score_left !== 4'd0) begin n_fail++; $display("FAIL point_score: L=%0d R=%0d want 0/1", bus.score_left, bus.score_right); end
        n_checks++; if (bus.serve_dir !== 1'b0 || bus.ball_run !== 1'b0 || bus.ball_load !== 1'b0) begin
            n_fail++; $display("FAIL point_flags: dir=%b run=%b load=%b want 0/0/0", bus.serve_dir, bus.ball_run, bus.ball_load); end
        frame_pulse();
        n_checks++; if (bus.state !== 3'd3) begin n_fail++; $display("FAIL point_hold: got %0d want 3", bus.state); end
        frame_pulse();
        n_checks++; if (bus.state !== 3'd1 || bus.ball_load !== 1'b1) begin n_fail++; $display("FAIL point_to_serve: state=%0d load=%b want 1/1", bus.state, bus.ball_load); end
    endtask

    task automatic test_let();
        repeat (3) frame_pulse();
        n_checks++; if (bus.state !== 3'd2) begin n_fail++; $display("FAIL let_play: got %0d want 2", bus.state); end
        bus.miss_left  = 1'b1;
        bus.miss_right = 1'b1;
        tick();
        bus.miss_left  = 1'b0;
        bus.miss_right = 1'b0;
        n_checks++; if (bus.state !== 3'd1) begin n_fail++; $display("FAIL let_state: got %0d want 1", bus.state); end
        n_checks++; if (bus.score_left !== 4'd0 || bus.score_right !== 4'd1 || bus.serve_dir !== 1'b0) begin
            n_fail++; $display("FAIL let_score: L=%0d R=%0d dir=%b want 0/1/0", bus.score_left, bus.score_right, bus.serve_dir); end
    endtask

    task automatic test_game_over();
        for (int p = 1; p <= 2; p++) begin
            repeat (3) frame_pulse();
            bus.miss_right = 1'b1;
            tick();
            bus.miss_right = 1'b0;
            n_checks++; if (bus.score_left !== 4'(p) || bus.serve_dir !== 1'b1) begin
                n_fail++; $display("FAIL win_point%0d: L=%0d dir=%b want %0d/1", p, bus.score_left, bus.serve_dir, p); end
            repeat (2) frame_pulse();
        end
        n_checks++; if (bus.state !== 3'd5 || bus.game_over !== 1'b1 || bus.winner !== 1'b0) begin
            n_fail++; $display("FAIL over_state: state=%0d over=%b winner=%b want 5/1/0", bus.state, bus.game_over, bus.winner); end
        n_checks++; if (bus.ball_run !== 1'b0 || bus.ball_load !== 1'b1) begin n_fail++; $display("FAIL over_flags: run=%b load=%b want 0/1", bus.ball_run, bus.ball_load); end
        bus.miss_left = 1'b1;
        tick();
        bus.miss_left = 1'b0;
        tick();
        n_checks++; if (bus.score_right !== 4'd1 || bus.state !== 3'd5) begin n_fail++; $display("FAIL over_miss: R=%0d state=%0d want 1/5", bus.score_right, bus.state); end
        bus.start_btn = 1'b1;
        tick();
        bus.start_btn = 1'b0;
        n_checks++; if (bus.state !== 3'd1 || bus.game_over !== 1'b0) begin n_fail++; $display("FAIL restart: state=%0d over=%b want 1/0", bus.state, bus.game_over); end
        n_checks++; if (bus.score_left !== 4'd0 || bus.score_right !== 4'd0 || bus.serve_dir !== 1'b1) begin
            n_fail++; $display("FAIL restart_scores: L=%0d R=%0d dir=%b want 0/0/1", bus.score_left, bus.score_right, bus.serve_dir); end
        tick();
    endtask

    task automatic test_pause_and_reset();
        repeat (3) frame_pulse();
        bus.pause_btn = 1'b1;
        tick();
        bus.pause_btn = 1'b0;
        n_checks++; if (bus.state !== 3'd4 || bus.ball_run !== 1'b0 || bus.ball_load !== 1'b0) begin
            n_fail++; $display("FAIL pause_state: state=%0d run=%b load=%b want 4/0/0", bus.state, bus.ball_run, bus.ball_load); end
        bus.miss_left = 1'b1;
        tick();
        bus.miss_left = 1'b0;
        n_checks++; if (bus.state !== 3'd4 || bus.score_right !== 4'd0) begin n_fail++; $display("FAIL pause_miss: state=%0d R=%0d want 4/0", bus.state, bus.score_right); end
        bus.pause_btn = 1'b1;
        tick();
        bus.pause_btn = 1'b0;
        n_checks++; if (bus.state !== 3'd2 || bus.ball_run !== 1'b1) begin n_fail++; $display("FAIL unpause: state=%0d run=%b want 2/1", bus.state, bus.ball_run); end
        n_checks++; if (bus.score_left !== 4'd0 || bus.score_right !== 4'd0) begin n_fail++; $display("FAIL unpause_scores: L=%0d R=%0d want 0/0", bus.score_left, bus.score_right); end
        bus.miss_left = 1'b1;
        tick();
        bus.miss_left = 1'b0;
        n_checks++; if (bus.state !== 3'd3 || bus.score_right !== 4'd1) begin n_fail++; $display("FAIL pre_reset_point: state=%0d R=%0d want 3/1", bus.state, bus.score_right); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++; if (bus.state !== 3'd0 || bus.score_right !== 4'd0 || bus.ball_load !== 1'b1 || bus.serve_dir !== 1'b1) begin
            n_fail++; $display("FAIL mid_point_reset: state=%0d R=%0d load=%b dir=%b want 0/0/1/1",
                bus.state, bus.score_right, bus.ball_load, bus.serve_dir); end
    endtask

    initial begin
        reset          = 1'b1;
        bus.vsync      = 1'b1;
        bus.start_btn  = 1'b0;
        bus.pause_btn  = 1'b0;
        bus.miss_left  = 1'b0;
        bus.miss_right = 1'b0;
        test_reset();
        test_serve_delay();
        test_point();
        test_let();
        test_game_over();
        test_pause_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Game-flow sequencer for the pong video datapath. Runs IDLE/serve/play/point/pause/game-over sequencing, keeps both scores, and gates the ball engine through run/load/serve-direction controls. Paced by frame ticks derived from the VGA vsync output. Sits between the VGA timing counters, the ball engine and the score overlay.

Parameters:
SERVE_DELAY_FRAMES, 60, frame ticks the ball is held at centre before launch (1..2^FRAME_CNT_W-1)
POINT_HOLD_FRAMES, 30, frame ticks the ball is frozen after a point (1..2^FRAME_CNT_W-1)
WIN_SCORE, 7, score that ends the game (1..2^SCORE_W-1)
SCORE_W, 4, score counter width
FRAME_CNT_W, 8, frame delay counter width

Ports:
clk  in  1  pixel clock (divided clock feeding the VGA counters)
reset  in  1  synchronous, active-high reset
vsync  in  1  VGA vsync, active-low, synchronous to clk
start_btn  in  1  start/restart level input, synchronous to clk
pause_btn  in  1  pause toggle level input, synchronous to clk
miss_left  in  1  one-cycle pulse: ball passed left boundary (point to right player)
miss_right  in  1  one-cycle pulse: ball passed right boundary (point to left player)
ball_run  out  1  ball engine may move
ball_load  out  1  ball engine holds ball at screen centre
serve_dir  out  1  launch direction: 1 = toward right, 0 = toward left
score_left  out  SCORE_W  left player score
score_right  out  SCORE_W  right player score
game_over  out  1  high in OVER state
winner  out  1  valid while game_over: 0 = left, 1 = right
state  out  3  encoded state for debug: IDLE=0, SERVE=1, PLAY=2, POINT=3, PAUSE=4, OVER=5

Behaviour:
- All outputs registered. Reset: state=IDLE, scores=0, serve_dir=1, ball_run=0, ball_load=1, game_over=0, winner=0, frame_cnt=0.
- Edge detectors: vsync_q, start_q, pause_q reset to 1, so a button held through reset does not fire.
- frame_tick = vsync_q & ~vsync (falling edge), one cycle wide, used in the same cycle.
- start_rise = ~start_q & start_btn; pause_rise likewise.
- Output map by state:
  - IDLE and SERVE: run=0, load=1.
  - PLAY: run=1, load=0.
  - POINT and PAUSE: run=0, load=0 (ball frozen in place).
  - OVER: run=0, load=1, game_over=1.
- IDLE: start_rise -> SERVE, frame_cnt=0.
- SERVE: frame_cnt += 1 on each frame_tick. On the tick where frame_cnt == SERVE_DELAY_FRAMES-1 -> PLAY, frame_cnt=0.
- PLAY transitions, in priority order:
  - miss_left & miss_right in the same cycle: let, no score change, serve_dir unchanged -> SERVE.
  - miss_left: score_right += 1, serve_dir=0 -> POINT.
  - miss_right: score_left += 1, serve_dir=1 -> POINT.
  - pause_rise (only if no miss that cycle) -> PAUSE.
  - Scores update on the same clock edge as the state change.
- PAUSE: pause_rise -> PLAY. Misses are ignored. frame_cnt is untouched.
- POINT: count frame ticks as in SERVE, up to POINT_HOLD_FRAMES-1. On that final tick:
  - score_left == WIN_SCORE -> OVER, winner=0.
  - else score_right == WIN_SCORE -> OVER, winner=1.
  - else -> SERVE, frame_cnt=0.
- OVER: scores held. start_rise -> scores=0, serve_dir=1, game_over=0 -> SERVE.
- Scores saturate at 2^SCORE_W-1 and never wrap (unreachable when WIN_SCORE is legal).
- Miss pulses outside PLAY are ignored.
- start_rise outside IDLE and OVER is ignored. pause_rise outside PLAY and PAUSE is ignored.
- reset asserted in any state forces the reset values on the next edge and takes priority over all inputs.
- Latency: input event -> output change is 1 clk.

Test Plan:
1. Reset with start_btn held high, then release and re-press -> IDLE persists while held; SERVE entered 1 clk after the rising edge, with ball_load=1.
2. SERVE_DELAY_FRAMES=3, vsync pulsed 3 times -> PLAY (ball_run=1, ball_load=0) 1 clk after the 3rd falling edge, not before.
3. In PLAY, pulse miss_left -> 1 clk later score_right=1, serve_dir=0, state=POINT, run=0. After POINT_HOLD_FRAMES ticks -> SERVE.
4. miss_left and miss_right in the same cycle -> scores unchanged, state=SERVE, serve_dir unchanged.
5. WIN_SCORE=2, two miss_right points -> score_left=2, OVER after the hold, game_over=1, winner=0. Further misses ignored. start_rise -> scores 0, SERVE.
6. Pause in PLAY, then miss_left during PAUSE, then un-pause -> state=PAUSE with run=0 and the miss ignored; after second pause_rise, PLAY resumes with scores unchanged. Reset mid-POINT -> IDLE, scores 0 next clk.
